spi_dac_frame_receiver: RTL and testbench

SPI_DAC_FRAME_RECEIVER -- requirements
Module: spi_dac_frame_receiver

---
 rtl/spi_dac_pkg.sv | 18 +
 rtl/spi_input_synchronizer.sv | 58 +++++
 rtl/spi_dac_frame_receiver.sv | 162 ++++++++++++++++
 tb/tb_spi_dac_frame_receiver.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/spi_dac_pkg.sv
// Shared types and constants for the SPI DAC frame receiver.
package spi_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int DAC_FRAME_BITS = 16;
    localparam int DAC_DATA_BITS  = 12;

    localparam logic [1:0] MODE_NORMAL  = 2'b00;
    localparam logic [1:0] MODE_PD_1K   = 2'b01;
    localparam logic [1:0] MODE_PD_100K = 2'b10;
    localparam logic [1:0] MODE_PD_HIZ  = 2'b11;

endpackage

// File: rtl/spi_input_synchronizer.sv
// N-flop synchronizer for one asynchronous input, with a registered copy of
// the previous synchronized value and registered rise/fall pulses. Edge
// pulses are suppressed until both the chain and the previous-value flop
// hold real samples, so stale reset values never produce a false edge.
module spi_input_synchronizer #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync_o,
    output logic prev_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] stage_q, stage_d;
    logic [STAGES:0]   vld_q, vld_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // Next-state: shift the chain, age the valid mask, detect edges.
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        vld_d  = {vld_q[STAGES-1:0], 1'b1};
        prev_d = stage_q[STAGES-1];
        rise_d = vld_q[STAGES] & stage_q[STAGES-1] & ~prev_q;
        fall_d = vld_q[STAGES] & ~stage_q[STAGES-1] & prev_q;
    end

    // Synchronizer, previous-value and edge-pulse registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_q <= {STAGES{RESET_VAL}};
            vld_q   <= {(STAGES+1){1'b0}};
            prev_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            vld_q   <= vld_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sync_o = stage_q[STAGES-1];
    assign prev_o = prev_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_dac_frame_receiver.sv
// Receives 16-bit DAC command frames over a slow SPI link that is
// oversampled by the 50 MHz system clock. Captures 12 data bits and the
// 2-bit power-down mode of each complete frame and flags short/long frames.
module spi_dac_frame_receiver
    import spi_dac_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = DAC_FRAME_BITS
) (
    input  logic        clock_50Mhz,
    input  logic        reset_n,
    input  logic        input_SPI_SCLK,
    input  logic        input_SPI_SYNC_n,
    input  logic        input_SPI_DIN,
    output logic [11:0] receivedSample,
    output logic [1:0]  receivedMode,
    output logic        sampleValid,
    output logic        frameError,
    output logic        isBusy
);

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    logic sclk_level_s, sclk_prev_s, sclk_rise_s, sclk_fall_s;
    logic sync_level_s, sync_prev_s, sync_rise_s, sync_fall_s;
    logic din_s;
    logic [4:0] cnt_inc_s;
    logic unused_s;

    state_e                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [11:0]             sample_q, sample_d;
    logic [1:0]              mode_q, mode_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    err_seen_q, err_seen_d;
    logic [SYNC_STAGES:0]    din_pipe_q, din_pipe_d;

    spi_input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk     (clock_50Mhz),
        .reset_n (reset_n),
        .din     (input_SPI_SCLK),
        .sync_o  (sclk_level_s),
        .prev_o  (sclk_prev_s),
        .rise_o  (sclk_rise_s),
        .fall_o  (sclk_fall_s)
    );

    spi_input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sync_n (
        .clk     (clock_50Mhz),
        .reset_n (reset_n),
        .din     (input_SPI_SYNC_n),
        .sync_o  (sync_level_s),
        .prev_o  (sync_prev_s),
        .rise_o  (sync_rise_s),
        .fall_o  (sync_fall_s)
    );

    // DIN gets one flop beyond the synchronizer depth so it lines up with
    // the registered SCLK rise pulse.
    assign din_s     = din_pipe_q[SYNC_STAGES];
    assign cnt_inc_s = cnt_q + 5'd1;
    assign isBusy    = (state_q != ST_IDLE);
    assign unused_s  = ^{sclk_level_s, sclk_prev_s, sclk_fall_s, sync_prev_s, shift_q[FRAME_BITS-1]};

    // Frame FSM: next state, shift/count update and output pulses.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        sample_d   = sample_q;
        mode_d     = mode_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        err_seen_d = err_seen_q;
        din_pipe_d = {din_pipe_q[SYNC_STAGES-1:0], input_SPI_DIN};

        case (state_q)
            ST_IDLE: begin
                if (sync_fall_s) begin
                    state_d    = ST_SHIFT;
                    cnt_d      = 5'd0;
                    shift_d    = {FRAME_BITS{1'b0}};
                    err_seen_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == FRAME_CNT) begin
                    state_d  = ST_DRAIN;
                    sample_d = shift_q[DAC_DATA_BITS-1:0];
                    mode_d   = shift_q[DAC_DATA_BITS+1:DAC_DATA_BITS];
                    valid_d  = 1'b1;
                end else begin
                    if (sclk_rise_s) begin
                        shift_d = {shift_q[FRAME_BITS-2:0], din_s};
                        cnt_d   = cnt_inc_s;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    // A bit landing with the SYNC_n rise counts first; if it
                    // completes the frame the capture happens next cycle.
                    if (sync_rise_s && !(sclk_rise_s && (cnt_inc_s == FRAME_CNT))) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_DRAIN: begin
                if (sclk_rise_s && !err_seen_q) begin
                    err_d      = 1'b1;
                    err_seen_d = 1'b1;
                end else begin
                    err_d = 1'b0;
                end
                if (sync_level_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clock_50Mhz) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            shift_q    <= {FRAME_BITS{1'b0}};
            sample_q   <= 12'd0;
            mode_q     <= MODE_NORMAL;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_seen_q <= 1'b0;
            din_pipe_q <= {(SYNC_STAGES+1){1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            sample_q   <= sample_d;
            mode_q     <= mode_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_seen_q <= err_seen_d;
            din_pipe_q <= din_pipe_d;
        end
    end

    assign receivedSample = sample_q;
    assign receivedMode   = mode_q;
    assign sampleValid    = valid_q;
    assign frameError     = err_q;

endmodule

// File: tb/tb_spi_dac_frame_receiver.sv
// Self-checking bench for spi_dac_frame_receiver: table-driven frames with a
// scoreboard of expected sampleValid/frameError pulses, plus a hand-written
// reset-mid-frame sequence.
module tb_spi_dac_frame_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 35;   // 70-cycle SCLK period, about 714 kHz

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sclk;
    logic        sync_n;
    logic        din;
    logic [11:0] receivedSample;
    logic [1:0]  receivedMode;
    logic        sampleValid;
    logic        frameError;
    logic        isBusy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t16_cyc = 0;

    typedef struct {
        logic [15:0] data;
        int          nbits;
        int          gap;
        logic        exp_valid;
        logic        exp_err;
        logic [11:0] exp_sample;
        logic [1:0]  exp_mode;
    } vec_t;

    typedef struct {
        logic        is_valid;
        logic [11:0] sample;
        logic [1:0]  mode;
    } sb_t;

    vec_t vecs[8];
    sb_t  sb_q[$];

    spi_dac_frame_receiver #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BITS(16)) dut (
        .clock_50Mhz      (clk),
        .reset_n          (reset_n),
        .input_SPI_SCLK   (sclk),
        .input_SPI_SYNC_n (sync_n),
        .input_SPI_DIN    (din),
        .receivedSample   (receivedSample),
        .receivedMode     (receivedMode),
        .sampleValid      (sampleValid),
        .frameError       (frameError),
        .isBusy           (isBusy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Clock n bits MSB first: DIN set while SCLK is low, then SCLK pulses high.
    task automatic clock_bits(input logic [15:0] data, input int nbits);
        logic [15:0] sh;
        sh = data;
        for (int i = 0; i < nbits; i++) begin
            din = sh[15];
            sh  = sh << 1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            if (i == 15) t16_cyc = cyc;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] data, input int nbits, input int gap);
        sync_n = 1'b0;
        repeat (HALF) @(negedge clk);
        clock_bits(data, nbits);
        repeat (HALF) @(negedge clk);
        sync_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Scoreboard: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        sb_t e;
        if (sampleValid || frameError) begin
            check("pulse_exclusive", 32'(sampleValid & frameError), 32'd0);
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected no pulse (t=%0t)",
                         sampleValid, frameError, $time);
            end else begin
                e = sb_q.pop_front();
                check("pulse_kind", 32'(sampleValid), 32'(e.is_valid));
                check("sample", 32'(receivedSample), 32'(e.sample));
                check("mode", 32'(receivedMode), 32'(e.mode));
                if (e.is_valid) begin
                    check("valid_latency", 32'(cyc - t16_cyc), 32'(SYNC_STAGES + 3));
                end else begin
                    check("err_not_busy_pulse", 32'(sampleValid), 32'd0);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0ABC, 16, 10, 1'b1, 1'b0, 12'hABC, 2'b00};
        vecs[1] = '{16'h3FFF, 16, 10, 1'b1, 1'b0, 12'hFFF, 2'b11};
        vecs[2] = '{16'h1001, 16, 10, 1'b1, 1'b0, 12'h001, 2'b01};
        vecs[3] = '{16'h0555,  9, 10, 1'b0, 1'b1, 12'h001, 2'b01};
        vecs[4] = '{16'h2A5C, 17, 10, 1'b1, 1'b1, 12'hA5C, 2'b10};
        vecs[5] = '{16'h0001, 16,  2, 1'b1, 1'b0, 12'h001, 2'b00};
        vecs[6] = '{16'h0FFE, 16, 10, 1'b1, 1'b0, 12'hFFE, 2'b00};
        vecs[7] = '{16'hC7D2, 16, 10, 1'b1, 1'b0, 12'h7D2, 2'b00};

        reset_n = 1'b0;
        sclk    = 1'b0;
        sync_n  = 1'b1;
        din     = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_sample", 32'(receivedSample), 32'd0);
        check("rst_mode", 32'(receivedMode), 32'd0);
        check("rst_valid", 32'(sampleValid), 32'd0);
        check("rst_err", 32'(frameError), 32'd0);
        check("rst_busy", 32'(isBusy), 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].exp_valid) sb_q.push_back('{1'b1, vecs[v].exp_sample, vecs[v].exp_mode});
            if (vecs[v].exp_err)   sb_q.push_back('{1'b0, vecs[v].exp_sample, vecs[v].exp_mode});
            send_frame(vecs[v].data, vecs[v].nbits, vecs[v].gap);
        end
        repeat (10) @(negedge clk);
        check("idle_after_table", 32'(isBusy), 32'd0);
        check("table_drained", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of a frame: partial frame vanishes silently and
        // the rest of it (SYNC_n still low) is ignored until SYNC_n goes high.
        sync_n = 1'b0;
        repeat (HALF) @(negedge clk);
        clock_bits(16'h0123, 8);
        check("busy_mid_frame", 32'(isBusy), 32'd1);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_sample", 32'(receivedSample), 32'd0);
        check("midrst_busy", 32'(isBusy), 32'd0);
        reset_n = 1'b1;
        clock_bits(16'h2300, 8);
        check("ignored_after_rst_busy", 32'(isBusy), 32'd0);
        repeat (HALF) @(negedge clk);
        sync_n = 1'b1;
        repeat (10) @(negedge clk);
        check("ignored_after_rst_sample", 32'(receivedSample), 32'd0);

        sb_q.push_back('{1'b1, 12'h123, 2'b00});
        send_frame(16'h0123, 16, 10);
        repeat (20) @(negedge clk);
        check("final_sample", 32'(receivedSample), 32'h123);
        check("final_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
